// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: bundles the control-unit request side, the multiplier/divider
// handshake and results, and the HI/LO/status outputs of muldiv_ctrl.
//
// Signals
//   start, op, a, b           request from the main control unit
//   mtoc, dtoc                multiplier / divider done (level)
//   mult_high, mult_low       multiplier result
//   div_high, div_low         divider result (remainder, quotient)
//   div_zero                  divider zero-divisor flag, valid with dtoc
//   ctom, ctod                multiplier / divider start strobes
//   op_a, op_b                operands latched at acceptance
//   hi, lo                    architectural HI/LO
//   busy                      high whenever the sequencer is not idle
//   done, div_zero_exc, timeout  one-cycle event pulses
//
// Modports
//   slave   the sequencer itself
//   master  everything around it (control unit plus both arithmetic units)
interface muldiv_ctrl_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mtoc;
    logic        dtoc;
    logic [31:0] mult_high;
    logic [31:0] mult_low;
    logic [31:0] div_high;
    logic [31:0] div_low;
    logic        div_zero;

    logic        ctom;
    logic        ctod;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero_exc;
    logic        timeout;

    modport slave (
        input  start, op, a, b, mtoc, dtoc, mult_high, mult_low, div_high, div_low, div_zero,
        output ctom, ctod, op_a, op_b, hi, lo, busy, done, div_zero_exc, timeout
    );

    modport master (
        output start, op, a, b, mtoc, dtoc, mult_high, mult_low, div_high, div_low, div_zero,
        input  ctom, ctod, op_a, op_b, hi, lo, busy, done, div_zero_exc, timeout
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer for the multicycle multiply/divide datapath.
// Accepts one operation at a time, launches the multiplier or divider with a
// one-cycle strobe, waits for that unit's done level, commits the result to the
// architectural HI/LO registers and reports completion, divide-by-zero and
// watchdog-timeout events as one-cycle pulses.
//
// Ports
//   clk   system clock, all state changes on the rising edge
//   rst   synchronous active-high reset
//   bus   muldiv_ctrl_if.slave: request, unit handshakes/results, HI/LO, status
//
// Parameter
//   MAX_CYCLES  watchdog limit in WAIT cycles (2..63)
module muldiv_ctrl #(
    parameter int unsigned MAX_CYCLES = 40
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_ctrl_if.slave bus
);

    localparam logic [1:0] OpMult = 2'b00;
    localparam logic [1:0] OpDiv  = 2'b01;
    localparam logic [1:0] OpMthi = 2'b10;
    localparam logic [1:0] OpMtlo = 2'b11;

    // Count holds the number of WAIT edges already spent, minus one.
    localparam logic [5:0] LastCount = 6'(MAX_CYCLES - 1);

    localparam logic UnitMult = 1'b0;
    localparam logic UnitDiv  = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    state_e      state_q;
    logic        unit_q;
    logic [5:0]  count_q;
    logic [31:0] op_a_q;
    logic [31:0] op_b_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        ctom_q;
    logic        ctod_q;
    logic        done_q;
    logic        div_zero_exc_q;
    logic        timeout_q;

    // Only the done level of the unit in flight is meaningful; the other one
    // may be stale from an earlier operation.
    logic unit_done;
    assign unit_done = (unit_q == UnitDiv) ? bus.dtoc : bus.mtoc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            unit_q         <= UnitMult;
            count_q        <= '0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            hi_q           <= '0;
            lo_q           <= '0;
            ctom_q         <= 1'b0;
            ctod_q         <= 1'b0;
            done_q         <= 1'b0;
            div_zero_exc_q <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            // Every pulse output is high for at most one cycle.
            ctom_q         <= 1'b0;
            ctod_q         <= 1'b0;
            done_q         <= 1'b0;
            div_zero_exc_q <= 1'b0;
            timeout_q      <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        unique case (bus.op)
                            OpMult: begin
                                op_a_q  <= bus.a;
                                op_b_q  <= bus.b;
                                unit_q  <= UnitMult;
                                ctom_q  <= 1'b1;
                                state_q <= StIssue;
                            end
                            OpDiv: begin
                                if (bus.b == '0) begin
                                    // Zero divisor is caught here; the divider is never launched.
                                    div_zero_exc_q <= 1'b1;
                                    done_q         <= 1'b1;
                                end else begin
                                    op_a_q  <= bus.a;
                                    op_b_q  <= bus.b;
                                    unit_q  <= UnitDiv;
                                    ctod_q  <= 1'b1;
                                    state_q <= StIssue;
                                end
                            end
                            OpMthi: begin
                                hi_q   <= bus.a;
                                done_q <= 1'b1;
                            end
                            OpMtlo: begin
                                lo_q   <= bus.a;
                                done_q <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end

                StIssue: begin
                    // Done levels are not looked at here: the unit has not yet
                    // seen its strobe and may still show the previous result.
                    count_q <= '0;
                    state_q <= StWait;
                end

                StWait: begin
                    if (unit_done) begin
                        if (unit_q == UnitMult) begin
                            hi_q <= bus.mult_high;
                            lo_q <= bus.mult_low;
                        end else if (!bus.div_zero) begin
                            hi_q <= bus.div_high;
                            lo_q <= bus.div_low;
                        end else begin
                            div_zero_exc_q <= 1'b1;
                        end
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else if (count_q == LastCount) begin
                        timeout_q <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        count_q <= count_q + 6'd1;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy         = (state_q != StIdle);
    assign bus.ctom         = ctom_q;
    assign bus.ctod         = ctod_q;
    assign bus.op_a         = op_a_q;
    assign bus.op_b         = op_b_q;
    assign bus.hi           = hi_q;
    assign bus.lo           = lo_q;
    assign bus.done         = done_q;
    assign bus.div_zero_exc = div_zero_exc_q;
    assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed self-checking bench for muldiv_ctrl. Inputs change
// and outputs are sampled on the falling clock edge; a monitor accumulates
// per-output high-cycle counts that the directed steps difference.
module tb_muldiv_ctrl;
    localparam int unsigned Max = 40;

    logic clk;
    logic rst;
    muldiv_ctrl_if bus ();

    muldiv_ctrl #(
        .MAX_CYCLES(Max)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int n_busy = 0;
    int n_ctom = 0;
    int n_ctod = 0;
    int n_done = 0;
    int n_dze  = 0;
    int n_to   = 0;
    int n_both = 0;

    always @(negedge clk) begin
        n_busy += int'(bus.busy === 1'b1);
        n_ctom += int'(bus.ctom === 1'b1);
        n_ctod += int'(bus.ctod === 1'b1);
        n_done += int'(bus.done === 1'b1);
        n_dze  += int'(bus.div_zero_exc === 1'b1);
        n_to   += int'(bus.timeout === 1'b1);
        n_both += int'(bus.done === 1'b1 && bus.timeout === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic request(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        tick();
        bus.start = 1'b0;
    endtask

    int s_busy, s_ctom, s_ctod, s_done, s_dze, s_to;

    task automatic snap();
        s_busy = n_busy;
        s_ctom = n_ctom;
        s_ctod = n_ctod;
        s_done = n_done;
        s_dze  = n_dze;
        s_to   = n_to;
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.a         = '0;
        bus.b         = '0;
        bus.mtoc      = 1'b0;
        bus.dtoc      = 1'b0;
        bus.mult_high = '0;
        bus.mult_low  = '0;
        bus.div_high  = '0;
        bus.div_low   = '0;
        bus.div_zero  = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        check("rst_opa", bus.op_a, 32'h0);
        check("rst_opb", bus.op_b, 32'h0);
        check("rst_flags", {27'd0, bus.busy, bus.ctom, bus.ctod, bus.done, bus.timeout}, 32'h0);
        check("rst_dze", 32'(bus.div_zero_exc), 32'h0);
        rst = 1'b0;
        tick();

        // MTHI
        snap();
        request(2'b10, 32'h1234_5678, 32'h0);
        check("mthi_done", 32'(bus.done), 32'h1);
        check("mthi_hi", bus.hi, 32'h1234_5678);
        check("mthi_lo", bus.lo, 32'h0);
        tick();
        check("mthi_done_pulse", 32'(bus.done), 32'h0);
        check("mthi_busy_cnt", 32'(n_busy - s_busy), 32'h0);

        // MULT 7*6, done sampled at the 33rd WAIT edge
        snap();
        request(2'b00, 32'd7, 32'd6);
        check("mult_issue_busy", 32'(bus.busy), 32'h1);
        check("mult_ctom", 32'(bus.ctom), 32'h1);
        check("mult_ctod", 32'(bus.ctod), 32'h0);
        check("mult_opa", bus.op_a, 32'd7);
        check("mult_opb", bus.op_b, 32'd6);
        repeat (33) tick();
        bus.mtoc      = 1'b1;
        bus.mult_high = 32'h0;
        bus.mult_low  = 32'd42;
        tick();
        bus.mtoc = 1'b0;
        check("mult_done", 32'(bus.done), 32'h1);
        check("mult_busy_end", 32'(bus.busy), 32'h0);
        check("mult_lo", bus.lo, 32'd42);
        check("mult_hi", bus.hi, 32'h0);
        tick();
        check("mult_busy_cnt", 32'(n_busy - s_busy), 32'd34);
        check("mult_ctom_cnt", 32'(n_ctom - s_ctom), 32'd1);
        check("mult_done_cnt", 32'(n_done - s_done), 32'd1);

        // DIV -7/2, with wrong-unit done and a Start coinciding with completion
        snap();
        request(2'b01, 32'hFFFF_FFF9, 32'd2);
        check("div_ctod", 32'(bus.ctod), 32'h1);
        bus.mtoc = 1'b1;
        repeat (3) tick();
        check("div_ignore_mtoc", 32'(bus.busy), 32'h1);
        bus.mtoc     = 1'b0;
        bus.dtoc     = 1'b1;
        bus.div_high = 32'hFFFF_FFFF;
        bus.div_low  = 32'hFFFF_FFFD;
        bus.start    = 1'b1;
        bus.op       = 2'b10;
        bus.a        = 32'hDEAD_BEEF;
        tick();
        bus.start = 1'b0;
        bus.dtoc  = 1'b0;
        check("div_done", 32'(bus.done), 32'h1);
        check("div_hi", bus.hi, 32'hFFFF_FFFF);
        check("div_lo", bus.lo, 32'hFFFF_FFFD);
        tick();
        check("div_late_start_hi", bus.hi, 32'hFFFF_FFFF);
        check("div_late_start_done", 32'(bus.done), 32'h0);
        check("div_ctom_cnt", 32'(n_ctom - s_ctom), 32'h0);

        // DIV by zero caught at acceptance
        request(2'b10, 32'h0000_00AA, 32'h0);
        tick();
        snap();
        request(2'b01, 32'd5, 32'h0);
        check("dz0_dze", 32'(bus.div_zero_exc), 32'h1);
        check("dz0_done", 32'(bus.done), 32'h1);
        check("dz0_busy", 32'(bus.busy), 32'h0);
        check("dz0_hi", bus.hi, 32'h0000_00AA);
        check("dz0_opa_held", bus.op_a, 32'hFFFF_FFF9);
        tick();
        check("dz0_pulse", 32'({bus.done, bus.div_zero_exc}), 32'h0);
        check("dz0_ctod_cnt", 32'(n_ctod - s_ctod), 32'h0);

        // Divider reports DivZero
        request(2'b01, 32'd100, 32'd3);
        tick();
        bus.dtoc     = 1'b1;
        bus.div_zero = 1'b1;
        bus.div_high = 32'h1111_1111;
        bus.div_low  = 32'h2222_2222;
        tick();
        bus.dtoc     = 1'b0;
        bus.div_zero = 1'b0;
        check("dz1_dze", 32'(bus.div_zero_exc), 32'h1);
        check("dz1_done", 32'(bus.done), 32'h1);
        check("dz1_hi", bus.hi, 32'h0000_00AA);
        check("dz1_lo", bus.lo, 32'hFFFF_FFFD);
        tick();

        // Watchdog
        snap();
        request(2'b00, 32'd3, 32'd4);
        repeat (Max) tick();
        check("wd_before", 32'({bus.busy, bus.timeout}), 32'h2);
        tick();
        check("wd_timeout", 32'(bus.timeout), 32'h1);
        check("wd_busy", 32'(bus.busy), 32'h0);
        check("wd_done", 32'(bus.done), 32'h0);
        check("wd_hi", bus.hi, 32'h0000_00AA);
        check("wd_lo", bus.lo, 32'hFFFF_FFFD);
        tick();
        check("wd_to_cnt", 32'(n_to - s_to), 32'h1);
        check("wd_busy_cnt", 32'(n_busy - s_busy), 32'(Max + 1));
        request(2'b11, 32'h55, 32'h0);
        check("wd_next_lo", bus.lo, 32'h55);

        // Start while busy, then reset in WAIT and a late done
        tick();
        request(2'b01, 32'd1, 32'd2);
        tick();
        request(2'b00, 32'd99, 32'd99);
        check("busy_start_opa", bus.op_a, 32'd1);
        check("busy_start_busy", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_hi", bus.hi, 32'h0);
        check("mid_rst_lo", bus.lo, 32'h0);
        check("mid_rst_opa", bus.op_a, 32'h0);
        check("mid_rst_flags", {27'd0, bus.busy, bus.ctom, bus.ctod, bus.done, bus.timeout}, 32'h0);
        snap();
        bus.dtoc = 1'b1;
        bus.mtoc = 1'b1;
        repeat (3) tick();
        bus.dtoc = 1'b0;
        bus.mtoc = 1'b0;
        tick();
        check("late_done_cnt", 32'(n_done - s_done), 32'h0);
        check("late_busy_cnt", 32'(n_busy - s_busy), 32'h0);
        check("never_both", 32'(n_both), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
